// File: rtl/dmem_responder.sv
// dmem_responder: memory-side end of the pipeline dmem interface.
// Accepts one word read or byte-masked write per request, holds it for
// LATENCY cycles (1..15), then returns the pre-write word with a one-cycle
// valid strobe. Optional feature macro: DMEM_FAULT_EN (adds o_dmem_fault
// for misaligned or out-of-range requests).
module dmem_responder #(
    parameter int DEPTH   = 1024,
    parameter int LATENCY = 1
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [31:0] i_dmem_addr,
    input  logic        i_dmem_ren,
    input  logic        i_dmem_wen,
    input  logic [31:0] i_dmem_wdata,
    input  logic [3:0]  i_dmem_mask,
    output logic        o_dmem_ready,
    output logic        o_dmem_valid,
    output logic [31:0] o_dmem_rdata
`ifdef DMEM_FAULT_EN
    ,
    output logic        o_dmem_fault
`endif
);

    localparam int IDX_W = $clog2(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_RESP
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic [3:0]         r_cnt;
    logic [31:0]        r_mem [DEPTH];
    logic [31:0]        r_pending;
    logic               r_pend_fault;
    logic               r_rsp_fault;

    logic [IDX_W-1:0]   w_idx;
    logic               w_accept;
    logic               w_fault;
    logic               w_wr_en;
    logic [31:0]        w_rd_word;
    logic               w_unused_addr;

    assign w_idx    = i_dmem_addr[IDX_W+1:2];
    assign w_accept = (i_dmem_ren | i_dmem_wen) & o_dmem_ready;

`ifdef DMEM_FAULT_EN
    // Misaligned, or any address bit above the array span set.
    assign w_fault = (|i_dmem_addr[1:0]) | (|i_dmem_addr[31:IDX_W+2]);
`else
    assign w_fault = 1'b0;
`endif

    // Without the fault check, low bits are ignored and high bits wrap.
    assign w_unused_addr = ^{i_dmem_addr[31:IDX_W+2], i_dmem_addr[1:0]};

    // ren & wen together is a write; the response still carries the old word.
    assign w_wr_en   = w_accept & i_dmem_wen & ~w_fault;
    assign w_rd_word = w_fault ? 32'h0 : r_mem[w_idx];

    // Array write: each enabled byte lane commits at the accept edge.
    // NOTE: the array has no reset so it maps onto RAM and survives a reset pulse.
    always_ff @(posedge i_clk) begin
        for (int b = 0; b < 4; b++) begin
            if (w_wr_en && i_dmem_mask[b]) begin
                r_mem[w_idx][8*b +: 8] <= i_dmem_wdata[8*b +: 8];
            end
        end
    end

    // State register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic: accept from IDLE or RESP, count down in WAIT.
    always_comb begin
        // NOTE: default first so every path assigns and no latch is inferred.
        w_state_next = r_state;
        case (r_state)
            ST_IDLE, ST_RESP: begin
                if (w_accept) begin
                    w_state_next = (LATENCY == 1) ? ST_RESP : ST_WAIT;
                end else begin
                    w_state_next = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (r_cnt == 4'd1) begin
                    w_state_next = ST_RESP;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // Output logic: ready whenever no request is being held.
    always_comb begin
        o_dmem_ready = (r_state == ST_IDLE) || (r_state == ST_RESP);
        o_dmem_valid = (r_state == ST_RESP);
    end

`ifdef DMEM_FAULT_EN
    assign o_dmem_fault = (r_state == ST_RESP) & r_rsp_fault;
`endif

    // Latency counter: loaded at accept, decremented while waiting.
    // NOTE: sequential state uses non-blocking assignments throughout.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= 4'd0;
        end else if (w_accept) begin
            r_cnt <= 4'(LATENCY - 1);
        end else if (r_state == ST_WAIT) begin
            r_cnt <= r_cnt - 4'd1;
        end
    end

    // Pending word captured at the accept edge (pre-write contents).
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_pending    <= 32'h0;
            r_pend_fault <= 1'b0;
        end else if (w_accept) begin
            r_pending    <= w_rd_word;
            r_pend_fault <= w_fault;
        end
    end

    // Response data loads on entry to RESP; with LATENCY=1 that is the accept edge.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_dmem_rdata <= 32'h0;
            r_rsp_fault  <= 1'b0;
        end else if (w_state_next == ST_RESP) begin
            o_dmem_rdata <= w_accept ? w_rd_word : r_pending;
            r_rsp_fault  <= w_accept ? w_fault : r_pend_fault;
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: one instance at LATENCY=1, one at
// LATENCY=4, sharing clock and reset. Inputs change and outputs are sampled
// on the falling edge. Optional feature macro: DMEM_FAULT_EN.
module tb_dmem_responder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic [31:0] addr1 = '0, wdata1 = '0, rdata1;
    logic        ren1 = 1'b0, wen1 = 1'b0, ready1, valid1;
    logic [3:0]  mask1 = '0;

    logic [31:0] addr4 = '0, wdata4 = '0, rdata4;
    logic        ren4 = 1'b0, wen4 = 1'b0, ready4, valid4;
    logic [3:0]  mask4 = '0;

`ifdef DMEM_FAULT_EN
    logic        fault1, fault4;
`endif

    int n_tests = 0;
    int n_fail  = 0;
    logic seen_valid;

    always #5 clk = ~clk;

    dmem_responder #(.DEPTH(1024), .LATENCY(1)) u_dut1 (
        .i_clk(clk), .i_rst_n(rst_n), .i_dmem_addr(addr1), .i_dmem_ren(ren1),
        .i_dmem_wen(wen1), .i_dmem_wdata(wdata1), .i_dmem_mask(mask1),
        .o_dmem_ready(ready1), .o_dmem_valid(valid1), .o_dmem_rdata(rdata1)
`ifdef DMEM_FAULT_EN
        , .o_dmem_fault(fault1)
`endif
    );

    dmem_responder #(.DEPTH(1024), .LATENCY(4)) u_dut4 (
        .i_clk(clk), .i_rst_n(rst_n), .i_dmem_addr(addr4), .i_dmem_ren(ren4),
        .i_dmem_wen(wen4), .i_dmem_wdata(wdata4), .i_dmem_mask(mask4),
        .o_dmem_ready(ready4), .o_dmem_valid(valid4), .o_dmem_rdata(rdata4)
`ifdef DMEM_FAULT_EN
        , .o_dmem_fault(fault4)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Present a request to the LATENCY=1 instance and let one rising edge pass.
    task automatic req1(input logic ren, input logic wen, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] mask);
        ren1 = ren; wen1 = wen; addr1 = addr; wdata1 = wdata; mask1 = mask;
        @(negedge clk);
    endtask

    task automatic set4(input logic ren, input logic wen, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] mask);
        ren4 = ren; wen4 = wen; addr4 = addr; wdata4 = wdata; mask4 = mask;
    endtask

    initial begin
        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_ready1", 32'(ready1), 32'd1);
        chk("rst_valid1", 32'(valid1), 32'd0);
        chk("rst_rdata1", rdata1, 32'h0);
        chk("rst_ready4", 32'(ready4), 32'd1);
        rst_n = 1'b1;
        @(negedge clk);

        // 1: LATENCY=1 write then read of 0x100
        req1(1'b0, 1'b1, 32'h100, 32'hA5A5_1234, 4'hF);
        chk("t1_wr_valid", 32'(valid1), 32'd1);
        chk("t1_wr_ready", 32'(ready1), 32'd1);
        req1(1'b1, 1'b0, 32'h100, 32'h0, 4'h0);
        chk("t1_rd_valid", 32'(valid1), 32'd1);
        chk("t1_rd_ready", 32'(ready1), 32'd1);
        chk("t1_rd_data", rdata1, 32'hA5A5_1234);
        req1(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        chk("t1_idle_valid", 32'(valid1), 32'd0);

        // 2: byte lanes on word 0
        req1(1'b0, 1'b1, 32'h0, 32'h1122_3344, 4'hF);
        req1(1'b0, 1'b1, 32'h0, 32'h00EE_0000, 4'b0100);
        chk("t2_lane_wr_old", rdata1, 32'h1122_3344);
        req1(1'b1, 1'b0, 32'h0, 32'h0, 4'h0);
        chk("t2_lane_rd", rdata1, 32'h11EE_3344);
        req1(1'b0, 1'b1, 32'h0, 32'hFFFF_FFFF, 4'b0000);
        chk("t2_mask0_valid", 32'(valid1), 32'd1);
        chk("t2_mask0_old", rdata1, 32'h11EE_3344);
        req1(1'b1, 1'b0, 32'h0, 32'h0, 4'h0);
        chk("t2_mask0_rd", rdata1, 32'h11EE_3344);

        // 4: ren&wen on 0x8 returns the old word, then the new one
        req1(1'b0, 1'b1, 32'h8, 32'h0, 4'hF);
        req1(1'b1, 1'b1, 32'h8, 32'hFFFF_FFFF, 4'hF);
        chk("t4_rw_valid", 32'(valid1), 32'd1);
        chk("t4_rw_old", rdata1, 32'h0);
        req1(1'b1, 1'b0, 32'h8, 32'h0, 4'h0);
        chk("t4_rd_new", rdata1, 32'hFFFF_FFFF);
        req1(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);

        // 3: LATENCY=4 write; a different write held while busy is ignored
        set4(1'b0, 1'b1, 32'h40, 32'hCAFE_F00D, 4'hF);
        @(negedge clk);
        set4(1'b0, 1'b1, 32'h40, 32'h0BAD_0BAD, 4'hF);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("t3_busy_ready%0d", i), 32'(ready4), 32'd0);
            chk($sformatf("t3_busy_valid%0d", i), 32'(valid4), 32'd0);
            @(negedge clk);
        end
        chk("t3_resp_valid", 32'(valid4), 32'd1);
        chk("t3_resp_ready", 32'(ready4), 32'd1);
        set4(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        @(negedge clk);
        chk("t3_after_valid", 32'(valid4), 32'd0);
        set4(1'b1, 1'b0, 32'h40, 32'h0, 4'h0);
        @(negedge clk);
        set4(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        repeat (3) @(negedge clk);
        chk("t3_rd_valid", 32'(valid4), 32'd1);
        chk("t3_rd_data", rdata4, 32'hCAFE_F00D);

        // 5: reset during WAIT
        set4(1'b0, 1'b1, 32'h44, 32'h1234_5678, 4'hF);
        @(negedge clk);
        set4(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        repeat (3) @(negedge clk);
        chk("t5_wr_valid", 32'(valid4), 32'd1);
        set4(1'b1, 1'b0, 32'h44, 32'h0, 4'h0);
        @(negedge clk);
        set4(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        chk("t5_wait_ready", 32'(ready4), 32'd0);
        #2 rst_n = 1'b0;
        #1;
        chk("t5_rst_valid", 32'(valid4), 32'd0);
        chk("t5_rst_rdata", rdata4, 32'h0);
        chk("t5_rst_ready", 32'(ready4), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        seen_valid = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (valid4) seen_valid = 1'b1;
        end
        chk("t5_no_late_valid", 32'(seen_valid), 32'd0);
        set4(1'b1, 1'b0, 32'h44, 32'h0, 4'h0);
        @(negedge clk);
        set4(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        repeat (3) @(negedge clk);
        chk("t5_rd_valid", 32'(valid4), 32'd1);
        chk("t5_rd_retained", rdata4, 32'h1234_5678);
        req1(1'b1, 1'b0, 32'h100, 32'h0, 4'h0);
        chk("t5_rd1_retained", rdata1, 32'hA5A5_1234);
        req1(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);

`ifdef DMEM_FAULT_EN
        // 6: fault reporting
        req1(1'b0, 1'b1, 32'h1000, 32'hDEAD_DEAD, 4'hF);
        chk("t6_oor_valid", 32'(valid1), 32'd1);
        chk("t6_oor_fault", 32'(fault1), 32'd1);
        req1(1'b1, 1'b0, 32'h0, 32'h0, 4'h0);
        chk("t6_word0_kept", rdata1, 32'h11EE_3344);
        chk("t6_ok_fault", 32'(fault1), 32'd0);
        req1(1'b1, 1'b0, 32'h2, 32'h0, 4'h0);
        chk("t6_mis_fault", 32'(fault1), 32'd1);
        chk("t6_mis_rdata", rdata1, 32'h0);
        req1(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        chk("t6_idle_fault", 32'(fault1), 32'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
